// File: rtl/uart_frame_loader.sv
// -----------------------------------------------------------------------------
// uart_frame_loader
//
// Packs the UART receive byte stream into 24-bit {R,G,B} pixels and writes
// them to BRAM port A at sequential addresses, one single-cycle strobe per
// pixel. An inter-byte gap of TIMEOUT_CYCLES resynchronises the byte/pixel
// phase so an aborted transfer cannot skew the colour order of the next frame.
//
// Optional feature macro: UART_FRAME_LOADER_SYNC_HEADER_EN
//   defined   : every frame must be preceded by the header 0xAA, 0x55
//   undefined : the first byte after reset/timeout is byte 0 of pixel 0
//
// Ports
//   clk        in   system clock (100 MHz UART/BRAM-write domain)
//   rst        in   asynchronous active-high reset
//   rx_data    in   received byte, valid when rx_ready=1
//   rx_ready   in   byte strobe, back-to-back allowed
//   en         out  BRAM port A enable
//   we         out  BRAM port A write enable (always equals en)
//   addr       out  pixel write address
//   din        out  pixel data {R,G,B}, held between strobes
//   frame_done out  pulse with the write of the last pixel of a frame
//   busy       out  transfer in progress
// -----------------------------------------------------------------------------
module uart_frame_loader #(
    parameter int IMG_PIXELS     = 196608,
    parameter int ADDR_W         = 18,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              en,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [23:0]       din,
    output logic              frame_done,
    output logic              busy
);

    localparam int                TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_PIXELS - 1);
    localparam logic [TW-1:0]     GAP_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]     GAP_SAT  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {SYNC0, SYNC1, PIXEL} state_t;

`ifdef UART_FRAME_LOADER_SYNC_HEADER_EN
    localparam state_t RESET_STATE = SYNC0;
`else
    localparam state_t RESET_STATE = PIXEL;
`endif

    state_t            state_q, state_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [ADDR_W-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0]     gap_q, gap_d;
    logic [7:0]        red_q, red_d;
    logic [7:0]        grn_q, grn_d;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [23:0]       din_q, din_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              busy_now;

    assign busy_now = (bcnt_q != 2'd0) || (pcnt_q != '0) || (state_q == SYNC1);

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        pcnt_d  = pcnt_q;
        gap_d   = gap_q;
        red_d   = red_q;
        grn_d   = grn_q;
        addr_d  = addr_q;
        din_d   = din_q;
        en_d    = 1'b0;
        done_d  = 1'b0;

        if (rx_ready) begin
            // A byte always restarts the gap timer, even on the timeout cycle.
            gap_d = '0;
            case (state_q)
`ifdef UART_FRAME_LOADER_SYNC_HEADER_EN
                SYNC0: begin
                    if (rx_data == 8'hAA) state_d = SYNC1;
                end
                SYNC1: begin
                    // A repeated 0xAA may still be the start of a valid header.
                    if (rx_data == 8'h55)      state_d = PIXEL;
                    else if (rx_data != 8'hAA) state_d = SYNC0;
                end
`endif
                default: begin
                    case (bcnt_q)
                        2'd0: begin
                            red_d  = rx_data;
                            bcnt_d = 2'd1;
                        end
                        2'd1: begin
                            grn_d  = rx_data;
                            bcnt_d = 2'd2;
                        end
                        default: begin
                            bcnt_d = 2'd0;
                            en_d   = 1'b1;
                            addr_d = pcnt_q;
                            din_d  = {red_q, grn_q, rx_data};
                            // Explicit compare so non-power-of-two frames wrap correctly.
                            if (pcnt_q == LAST_PIX) begin
                                pcnt_d  = '0;
                                done_d  = 1'b1;
                                state_d = RESET_STATE;
                            end else begin
                                pcnt_d = pcnt_q + ADDR_W'(1);
                            end
                        end
                    endcase
                end
            endcase
        end else if (gap_q != GAP_SAT) begin
            gap_d = gap_q + TW'(1);
            // Resync fires once, on the cycle the timer reaches its limit.
            if (gap_q == GAP_LAST && busy_now) begin
                bcnt_d  = 2'd0;
                pcnt_d  = '0;
                state_d = RESET_STATE;
            end
        end

        busy_d = (bcnt_d != 2'd0) || (pcnt_d != '0) || (state_d == SYNC1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            bcnt_q  <= 2'd0;
            pcnt_q  <= '0;
            gap_q   <= '0;
            red_q   <= 8'd0;
            grn_q   <= 8'd0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= 24'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            pcnt_q  <= pcnt_d;
            gap_q   <= gap_d;
            red_q   <= red_d;
            grn_q   <= grn_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign en         = en_q;
    assign we         = en_q;
    assign addr       = addr_q;
    assign din        = din_q;
    assign frame_done = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_loader
//
// Directed scenarios followed by randomized byte streams with random spacing
// and occasional resets; every cycle the DUT outputs are compared with a
// byte-queue reference model of the frame loader.
// -----------------------------------------------------------------------------
module tb_uart_frame_loader;

    localparam int IMG_PIXELS     = 6;
    localparam int ADDR_W         = 3;
    localparam int TIMEOUT_CYCLES = 100;

`ifdef UART_FRAME_LOADER_SYNC_HEADER_EN
    localparam int HDR_START = 0;   // waiting for 0xAA
`else
    localparam int HDR_START = 2;   // pixel data accepted immediately
`endif

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic [7:0]        rx_data  = 8'd0;
    logic              rx_ready = 1'b0;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [23:0]       din;
    logic              frame_done;
    logic              busy;

    uart_frame_loader #(
        .IMG_PIXELS    (IMG_PIXELS),
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .en        (en),
        .we        (we),
        .addr      (addr),
        .din       (din),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: bytes of the pixel being assembled, pixel index,
    // idle cycles since the last byte, header progress (0 none, 1 saw 0xAA, 2 in frame).
    logic [7:0]  m_bytes[$];
    int          m_pix;
    int          m_idle;
    int          m_hdr;
    bit          m_en;
    bit          m_done;
    int          m_addr;
    logic [23:0] m_din;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_busy();
        return (m_bytes.size() != 0) || (m_pix != 0) || (m_hdr == 1);
    endfunction

    task automatic model_reset();
        m_bytes.delete();
        m_pix  = 0;
        m_idle = 0;
        m_hdr  = HDR_START;
        m_en   = 1'b0;
        m_done = 1'b0;
        m_addr = 0;
        m_din  = 24'd0;
    endtask

    task automatic model_step(input bit rdy, input logic [7:0] d);
        m_en   = 1'b0;
        m_done = 1'b0;
        if (rdy) begin
            m_idle = 0;
            if (m_hdr == 0) begin
                if (d == 8'hAA) m_hdr = 1;
            end else if (m_hdr == 1) begin
                if (d == 8'h55)      m_hdr = 2;
                else if (d != 8'hAA) m_hdr = 0;
            end else begin
                m_bytes.push_back(d);
                if (m_bytes.size() == 3) begin
                    m_en   = 1'b1;
                    m_addr = m_pix;
                    m_din  = {m_bytes[0], m_bytes[1], m_bytes[2]};
                    m_bytes.delete();
                    if (m_pix == IMG_PIXELS - 1) begin
                        m_pix  = 0;
                        m_done = 1'b1;
                        m_hdr  = HDR_START;
                    end else begin
                        m_pix++;
                    end
                end
            end
        end else if (m_idle < TIMEOUT_CYCLES) begin
            m_idle++;
            if (m_idle == TIMEOUT_CYCLES) begin
                m_bytes.delete();
                m_pix = 0;
                m_hdr = HDR_START;
            end
        end
    endtask

    task automatic compare_all(input string where);
        check_eq({where, ".en"},   32'(en),         32'(m_en));
        check_eq({where, ".we"},   32'(we),         32'(m_en));
        check_eq({where, ".done"}, 32'(frame_done), 32'(m_done));
        check_eq({where, ".busy"}, 32'(busy),       32'(model_busy()));
        check_eq({where, ".din"},  32'(din),        32'(m_din));
        if (m_en) check_eq({where, ".addr"}, 32'(addr), 32'(m_addr));
    endtask

    task automatic step(input bit rdy, input logic [7:0] d);
        @(negedge clk);
        rx_ready = rdy;
        rx_data  = d;
        @(posedge clk);
        model_step(rdy, d);
        #1;
        compare_all("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    task automatic send_hdr();
`ifdef UART_FRAME_LOADER_SYNC_HEADER_EN
        step(1'b1, 8'hAA);
        step(1'b1, 8'h55);
`endif
    endtask

    // Reset lands mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset();
        @(negedge clk);
        rx_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("rst");
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("por");
        rst = 1'b0;

        // Single pixel after reset.
        send_hdr();
        step(1'b1, 8'h12);
        step(1'b1, 8'h34);
        step(1'b1, 8'h56);
        check_eq("px0.en",   32'(en),   32'd1);
        check_eq("px0.addr", 32'(addr), 32'd0);
        check_eq("px0.din",  32'(din),  32'h123456);
        idle(3);
        check_eq("px0.hold", 32'(din),  32'h123456);

`ifdef UART_FRAME_LOADER_SYNC_HEADER_EN
        // Without a header nothing is written.
        idle(TIMEOUT_CYCLES);
        step(1'b1, 8'h12);
        step(1'b1, 8'h34);
        step(1'b1, 8'h56);
        check_eq("nohdr.en", 32'(en), 32'd0);
        // Noise then a doubled 0xAA before the header.
        step(1'b1, 8'h00);
        step(1'b1, 8'hAA);
        step(1'b1, 8'hAA);
        step(1'b1, 8'h55);
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        check_eq("hdr.en",   32'(en),   32'd1);
        check_eq("hdr.addr", 32'(addr), 32'd0);
        check_eq("hdr.din",  32'(din),  32'h112233);
`endif

        // Full frame, one byte per cycle.
        idle(TIMEOUT_CYCLES);
        send_hdr();
        for (int p = 0; p < IMG_PIXELS; p++) begin
            step(1'b1, 8'($urandom));
            step(1'b1, 8'($urandom));
            step(1'b1, 8'(p + 8'h40));
            check_eq("frm.en",   32'(en),   32'd1);
            check_eq("frm.addr", 32'(addr), 32'(p));
        end
        check_eq("frm.done", 32'(frame_done), 32'd1);
        check_eq("frm.busy", 32'(busy),       32'd0);
        send_hdr();
        step(1'b1, 8'hA1);
        step(1'b1, 8'hB2);
        step(1'b1, 8'hC3);
        check_eq("wrap.addr", 32'(addr), 32'd0);
        check_eq("wrap.din",  32'(din),  32'hA1B2C3);

        // Gap timeout discards the partial pixel.
        idle(TIMEOUT_CYCLES);
        send_hdr();
        step(1'b1, 8'hAB);
        step(1'b1, 8'hCD);
        idle(TIMEOUT_CYCLES);
        check_eq("tmo.busy", 32'(busy), 32'd0);
        send_hdr();
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        step(1'b1, 8'h03);
        check_eq("tmo.en",   32'(en),   32'd1);
        check_eq("tmo.addr", 32'(addr), 32'd0);
        check_eq("tmo.din",  32'(din),  32'h010203);

        // Reset between byte 1 and byte 2 of pixel 5.
        idle(TIMEOUT_CYCLES);
        send_hdr();
        for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom));
        check_eq("prerst.busy", 32'(busy), 32'd1);
        do_reset();
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.din",  32'(din),  32'd0);
        send_hdr();
        step(1'b1, 8'h77);
        step(1'b1, 8'h88);
        step(1'b1, 8'h99);
        check_eq("postrst.addr", 32'(addr), 32'd0);
        check_eq("postrst.din",  32'(din),  32'h778899);

        // Randomized streams with mixed spacing, header bytes and resets.
        for (int it = 0; it < 1500; it++) begin
            int          r;
            int          g;
            logic [7:0]  b;
            r = int'($urandom_range(0, 99));
            if (r < 65)      g = 0;
            else if (r < 92) g = int'($urandom_range(1, 6));
            else if (r < 96) g = int'($urandom_range(TIMEOUT_CYCLES - 2, TIMEOUT_CYCLES + 3));
            else             g = int'($urandom_range(7, 40));
            idle(g);
            if ($urandom_range(0, 249) == 0) do_reset();
            r = int'($urandom_range(0, 9));
            if (r == 0)      b = 8'hAA;
            else if (r == 1) b = 8'h55;
            else             b = 8'($urandom);
            step(1'b1, b);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Receive-side frame loader between the UART receiver and the dual-port frame buffer. It packs the byte stream from `rx_uart` into 24-bit RGB pixels and issues single-cycle write strobes to BRAM port A at sequential addresses. It detects end-of-frame and resynchronises after an inter-byte gap, so a truncated or aborted transfer never shifts the colour byte phase of the next frame. It runs entirely in the 100 MHz UART/BRAM-write domain.

## Interface
- `IMG_PIXELS`, 196608: pixels per frame (512×384); must be ≥ 2 and ≤ 2^ADDR_W.
- `ADDR_W`, 18: BRAM address width.
- `TIMEOUT_CYCLES`, 10_000_000: inter-byte gap, in clk cycles, that triggers resync; must be ≥ 16.
- `clk` in 1: system clock (CLK100M).
- `rst` in 1: reset; asynchronous, active-high.
- `rx_data` in 8: received byte; valid only in the cycle `rx_ready`=1.
- `rx_ready` in 1: byte strobe; arbitrary spacing, back-to-back allowed.
- `en` out 1: BRAM port A enable.
- `we` out 1: BRAM port A write enable; always equal to `en`.
- `addr` out ADDR_W: pixel write address.
- `din` out 24: pixel, {R,G,B}.
- `frame_done` out 1: one-cycle pulse coincident with the write of pixel IMG_PIXELS-1.
- `busy` out 1: transfer in progress.

## Operation
- Byte counter `bcnt` (0..2) and pixel counter `pcnt` (0..IMG_PIXELS-1).
- Byte order per pixel:
  - byte 0 → `din[23:16]`
  - byte 1 → `[15:8]`
  - byte 2 → `[7:0]`
- FSM states: SYNC0, SYNC1, PIXEL.
  - PIXEL: each accepted byte increments `bcnt`.
  - On byte 2: `bcnt`←0 and a write is issued at address `pcnt`; then `pcnt`←`pcnt`+1.
  - On the write of pixel IMG_PIXELS-1: `pcnt` wraps to 0, `frame_done` pulses, and the FSM goes to SYNC0 (macro defined) or stays in PIXEL (macro undefined).
- Gap timer: counts cycles since the last `rx_ready`. It restarts on every `rx_ready` and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES with `bcnt`≠0 or `pcnt`≠0 or state=SYNC1: `bcnt`←0, `pcnt`←0, FSM → its reset state.
  - No write is issued on timeout. The partial pixel is discarded; pixels already written stay in BRAM.
- `busy` = (`bcnt`≠0) | (`pcnt`≠0) | (state=SYNC1).
- Address arithmetic: `pcnt` is ADDR_W bits and compares against IMG_PIXELS-1, never relying on natural overflow.

## Timing
- All outputs are registered.
- Reset values: `en`=0, `we`=0, `addr`=0, `din`=0, `frame_done`=0, `busy`=0. Reset also sets `bcnt`=0, `pcnt`=0, gap timer=0, FSM = reset state.
- Write latency: if byte 2 has `rx_ready` at cycle n, then `en`=`we`=1 with valid `addr`/`din` during cycle n+1 only.
- `frame_done` is asserted in the same cycle as the final write strobe.
- `rx_ready` in the cycle a strobe is driven is accepted normally, as byte 0 of the next pixel. Sustained input of one byte per cycle loses no bytes.
- Timeout and `rx_ready` in the same cycle: `rx_ready` wins. The byte is processed normally and the timer restarts.
- Reset asserted mid-pixel or mid-frame: all state clears immediately (asynchronously). No strobe is issued for the partial pixel.
- `din` holds its last written value between strobes. Only `en`/`we` qualify it.

## Configuration
- `UART_FRAME_LOADER_SYNC_HEADER_EN` defined:
  - Reset state is SYNC0. Each frame must be preceded by header 0xAA, 0x55.
  - SYNC0: 0xAA → SYNC1; any other byte is ignored.
  - SYNC1: 0x55 → PIXEL; 0xAA stays in SYNC1; any other byte → SYNC0.
  - Header bytes are never written.
- Undefined:
  - SYNC0/SYNC1 are not implemented. Reset state is PIXEL, and the first byte after reset or timeout is byte 0 of pixel 0.

## Test plan
- Bytes 0x12, 0x34, 0x56 after reset (macro undefined) → exactly one cycle with `en`=`we`=1, `addr`=0, `din`=0x123456; no other strobes.
- IMG_PIXELS=4, 12 bytes sent back-to-back (one per cycle) → 4 strobes at addr 0,1,2,3 one cycle after each byte 2. `frame_done` is high only with the addr-3 strobe, then `busy`=0, and the next pixel writes addr 0.
- TIMEOUT_CYCLES=100: 0xAB, 0xCD, then 100 idle cycles, then 0x01, 0x02, 0x03 → no strobe for the discarded partial pixel; a single strobe at addr 0 with `din`=0x010203.
- Reset asserted between byte 1 and byte 2 of pixel 5 → outputs 0 in the same cycle. The following 3 bytes write addr 0.
- Macro defined: stream 0x00, 0xAA, 0xAA, 0x55, then 0x11, 0x22, 0x33 → one strobe at addr 0 with `din`=0x112233. Without the 0xAA, 0x55 header, no strobes occur.
- `rx_ready` for byte 0 of pixel 1 in the same cycle as the pixel-0 strobe → pixel 1 is assembled correctly and written at addr 1.
